pipelined_adder_nbit: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor. The datapath is split into SLICE-bit ripple segments, with one register stage per segment. The carry is registered between stages, so the critical path is one SLICE-bit ripple regardless of WIDTH. A valid/ready handshake on both sides lets it sit in the multiplier datapaths as a streaming accumulate/final-add stage with full backpressure.

---
 rtl/pipelined_adder_nbit.sv | 119 +++++++++++
 tb/tb_pipelined_adder_nbit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_nbit.sv
`timescale 1ns/1ps
// Streaming adder/subtractor resolving SLICE bits per register stage; latency STAGES cycles, 1 result/cycle.
// Full valid/ready backpressure: a stage accepts when empty or when its downstream moves; outputs hold while stalled.
module pipelined_adder_nbit #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] addend_one,
    input  logic [WIDTH-1:0] addend_two,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int STAGES = WIDTH / SLICE;

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("pipelined_adder_nbit: WIDTH must be a multiple of SLICE");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES:0]   rdy;

    // rdy[k]: stage k may load this cycle; a bubble anywhere downstream frees every stage above it.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SLICE;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]        a_cur;
        logic [REM-1:0]        b_cur;
        logic                  c_cur;
        logic                  v_cur;
        logic [SLICE:0]        part;
        logic [LO+SLICE-1:0]   s_nxt;
        logic                  v_q;
        logic                  c_q;
        logic [LO+SLICE-1:0]   s_q;

        if (k == 0) begin : g_first
            assign a_cur = addend_one;
            assign b_cur = sub ? ~addend_two : addend_two;
            assign c_cur = sub ? 1'b1 : carry_in;
            assign v_cur = in_valid;
            assign s_nxt = part[SLICE-1:0];
        end else begin : g_next
            assign a_cur = g_stage[k-1].g_pass.a_q;
            assign b_cur = g_stage[k-1].g_pass.b_q;
            assign c_cur = g_stage[k-1].c_q;
            assign v_cur = g_stage[k-1].v_q;
            assign s_nxt = {part[SLICE-1:0], g_stage[k-1].s_q};
        end

        assign part = {1'b0, a_cur[SLICE-1:0]} + {1'b0, b_cur[SLICE-1:0]}
                    + {{SLICE{1'b0}}, c_cur};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (rdy[k]) begin
                v_q <= v_cur;
                if (v_cur) begin
                    c_q <= part[SLICE];
                    s_q <= s_nxt;
                end
            end
        end

        assign vld[k] = v_q;

        if (k < STAGES - 1) begin : g_pass
            // Unresolved upper operand bits; their msb doubles as the sign bit for overflow.
            logic [REM-SLICE-1:0] a_q;
            logic [REM-SLICE-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (rdy[k] && v_cur) begin
                    a_q <= a_cur[REM-1:SLICE];
                    b_q <= b_cur[REM-1:SLICE];
                end
            end
        end else begin : g_last
            logic ov_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ov_q <= 1'b0;
                end else if (rdy[k] && v_cur) begin
                    ov_q <= (a_cur[REM-1] == b_cur[REM-1]) && (s_nxt[WIDTH-1] != a_cur[REM-1]);
                end
            end

            assign out_valid = v_q;
            assign sum       = s_q;
            assign carry_out = c_q;
            assign overflow  = ov_q;
        end
    end
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
`timescale 1ns/1ps
// Bench for the pipelined adder: a 4-stage instance and a single-stage instance checked against an arithmetic model.
module tb_pipelined_adder_nbit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic        iv4 = 1'b0;
    logic        iv1 = 1'b0;
    logic        ir4, ov4, co4, of4;
    logic        ir1, ov1, co1, of1;
    logic [15:0] s4, s1;
    logic        sel = 1'b0;
    logic        o_ready, o_valid, o_cout, o_ovf;
    logic [15:0] o_sum;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    pipelined_adder_nbit #(.WIDTH(16), .SLICE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .addend_one(a), .addend_two(b), .carry_in(cin), .sub(sub),
        .out_valid(ov4), .out_ready(out_ready), .sum(s4), .carry_out(co4), .overflow(of4));

    pipelined_adder_nbit #(.WIDTH(16), .SLICE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .addend_one(a), .addend_two(b), .carry_in(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .carry_out(co1), .overflow(of1));

    assign o_ready = sel ? ir1 : ir4;
    assign o_valid = sel ? ov1 : ov4;
    assign o_sum   = sel ? s1  : s4;
    assign o_cout  = sel ? co1 : co4;
    assign o_ovf   = sel ? of1 : of4;

    // Expected {overflow, carry_out, sum} from integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        logic [31:0] ux, uy, ur;
        int          sx, sy, sr;
        logic        co, ov;
        ux = {16'h0, x};
        uy = {16'h0, y};
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            ur = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + {31'h0, ci};
            co = ur[16];
            sr = sx + sy + int'({31'h0, ci});
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, ur[15:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; iv4 = 1'b0; iv1 = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_valid4 got=%0b want=0", ov4); end
        total++; if (s4 !== 16'h0) begin bad++; $display("FAIL reset_sum4 got=%h want=0000", s4); end
        total++; if ({co4, of4} !== 2'b00) begin bad++; $display("FAIL reset_flags4 got=%b want=00", {co4, of4}); end
        total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%0b want=0", ov1); end
        total++; if (s1 !== 16'h0) begin bad++; $display("FAIL reset_sum1 got=%h want=0000", s1); end
        total++; if ({co1, of1} !== 2'b00) begin bad++; $display("FAIL reset_flags1 got=%b want=00", {co1, of1}); end
        rst_n = 1'b1;
        #1;
        total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL reset_ready4 got=%0b want=1", ir4); end
        total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%0b want=1", ir1); end
    endtask

    task automatic test_add_sub(input bit one);
        logic [15:0] da [5] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000};
        logic [15:0] db [5] = '{16'h0001, 16'h0001, 16'h4321, 16'h0007, 16'h0001};
        logic        dc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] e;
        int          lat;
        int          lat_exp;
        sel = one;
        lat_exp = one ? 0 : 3;
        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i < 5) begin
                a = da[i]; b = db[i]; cin = dc[i]; sub = ds[i];
            end else begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end
            e = model(a, b, cin, sub);
            if (one) iv1 = 1'b1; else iv4 = 1'b1;
            #1;
            total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL addsub_ready[%0d] got=%0b want=1", i, o_ready); end
            @(posedge clk);
            #1 iv1 = 1'b0; iv4 = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!o_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            total++; if (lat !== lat_exp) begin bad++; $display("FAIL addsub_latency[%0d] got=%0d want=%0d", i, lat, lat_exp); end
            total++;
            if ({o_ovf, o_cout, o_sum} !== e) begin
                bad++;
                $display("FAIL addsub_result[%0d] stages1=%0b a=%h b=%h cin=%0b sub=%0b got ovf/cout/sum=%0b/%0b/%h want %0b/%0b/%h",
                         i, one, a, b, cin, sub, o_ovf, o_cout, o_sum, e[17], e[16], e[15:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single_stage();
        test_add_sub(1'b1);
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_q[$];
        logic        exp_rdy, acc, pop;
        int          sent, got, cyc, extra;
        sel = 1'b0;
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc < 9);
            if (sent < 8) begin
                iv4 = 1'b1; a = 16'(sent); b = 16'(16'h00F0 * sent); cin = 1'b0; sub = 1'b0;
            end else begin
                iv4 = 1'b0;
            end
            #1;
            exp_rdy = out_ready || (exp_q.size() < 4);
            total++; if (ir4 !== exp_rdy) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%0b want=%0b", cyc, ir4, exp_rdy); end
            if (ov4) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_spurious cyc=%0d got sum=%h want no output", cyc, s4);
                end else if ({of4, co4, s4} !== exp_q[0]) begin
                    bad++; $display("FAIL b2b_result cyc=%0d got=%h want=%h", cyc, {of4, co4, s4}, exp_q[0]);
                end
            end
            acc = iv4 && ir4;
            pop = ov4 && out_ready;
            @(posedge clk);
            if (pop && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            if (acc) begin
                exp_q.push_back(model(a, b, 1'b0, 1'b0));
                sent++;
            end
            cyc++;
        end
        total++; if (got !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
        @(negedge clk);
        iv4 = 1'b0; out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov4) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL b2b_duplicates got=%0d want=0", extra); end
    endtask

    task automatic test_async_reset();
        int lat, stale;
        sel = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv4 = 1'b1; a = 16'(i + 1); b = 16'h0100; cin = 1'b0; sub = 1'b0;
        end
        @(negedge clk);
        iv4 = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%0b want=1", ov4); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL arst_async_drop got=%0b want=0", ov4); end
        total++; if (s4 !== 16'h0) begin bad++; $display("FAIL arst_sum_clear got=%h want=0000", s4); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov4) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL arst_stale got=%0d want=0", stale); end
        a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; iv4 = 1'b1;
        @(posedge clk);
        #1 iv4 = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!ov4 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 3) begin bad++; $display("FAIL arst_new_latency got=%0d want=3", lat); end
        total++; if (s4 !== 16'h0002) begin bad++; $display("FAIL arst_new_sum got=%h want=0002", s4); end
    endtask

    initial begin
        test_reset();
        test_add_sub(1'b0);
        test_single_stage();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
